instruction_decode_unit: RTL and testbench
==========================================

Name: instruction_decode_unit

Overview:
- ID stage of the 6-stage MIPS32 pipeline (IF, ID, EX, MEM, SAD, WB).
- Decodes the IF/ID instruction and holds the 32x32 register file, written from WB.
- Resolves branches and jumps in ID and detects RAW hazards by stalling; the pipeline has no forwarding.
- All outputs are combinational from the inputs and the register-file state.

Parameters:
none

Ports:
- Clk  in  1  clock; register-file write on rising edge
- Reset  in  1  asynchronous active-high reset; clears the register file
- IF_ID_Instruction  in  32  instruction being decoded
- IF_ID_PC4  in  32  PC+4 of that instruction
- WB_WriteData  in  32  write-back data
- MEM_WB_WriteRegister  in  5  write-back destination
- MEM_WB_RegWrite  in  1  write-back enable
- ID_EX_RegWrite, EX_MEM_RegWrite, MEM_SAD_RegWrite  in  1 each  pending-write flags of EX, MEM, SAD
- EX_WriteRegister, EX_MEM_WriteRegister, MEM_SAD_WriteRegister  in  5 each  pending destinations
- ID_rs_val, ID_rt_val  out  32  register operands
- ID_ext_imm  out  32  extended immediate
- ID_rt, ID_rd, ID_shamt  out  5 each  instruction fields; ID_rd is 31 for jal
- ID_ALUControl  out  4  ALU operation
- ID_R  out  1  1 = second operand rt_val, destination rd; 0 = ext_imm, destination rt
- ID_RegWrite, ID_MemWrite, ID_MemRead, ID_HalfControl, ID_ByteControl  out  1 each  control flags
- ID_JALControl  out  1  link: EX result is PC4
- ID_frame_shift, ID_window_shift  out  1 each  SAD-load flags
- ID_PCSrc  out  1  redirect fetch
- ID_new_PC  out  32  redirect target
- ID_stall  out  1  hold PC and IF/ID; bubble into ID/EX

Behaviour:
- Register file
  - Reset clears all 32 registers to 0 asynchronously.
  - On posedge Clk, if MEM_WB_RegWrite=1 and dest!=0, the register is written.
  - $0 always reads 0.
  - Read bypass: if MEM_WB_RegWrite=1 and dest equals a nonzero read index, the read returns WB_WriteData in the same cycle.
- Fields: rs=[25:21], rt=[20:16], rd=[15:11], shamt=[10:6].
- Immediate: sign-extended [15:0]; zero-extended for andi, ori, xori.
- ALUControl encoding: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT, 7 SLTU, 8 SLL, 9 SRL, 10 SRA, 11 SLLV, 12 SRLV, 13 SRAV, 14 LUI, 15 MUL.
- R-type (op 00): ID_R=1, RegWrite=1.
  - add/addu 20/21, sub/subu 22/23, and 24, or 25, xor 26, nor 27, slt 2A, sltu 2B.
  - sll 00, srl 02, sra 03, sllv 04, srlv 06, srav 07.
  - mul: op 1C, funct 02.
- I-type: ID_R=0, RegWrite=1.
  - addi/addiu 08/09, slti 0A, sltiu 0B, andi 0C, ori 0D, xori 0E, lui 0F.
- Loads and stores (ADD address):
  - lw 23, lh 21 (Half), lb 20 (Byte): MemRead=1, RegWrite=1.
  - sw 2B, sh 29, sb 28: MemWrite=1, RegWrite=0.
- SAD loads behave as lw and additionally set one flag: 38 sets ID_frame_shift, 39 sets ID_window_shift.
- Branches and jumps have RegWrite=0 unless linking.
  - beq 04 / bne 05 compare rs_val with rt_val.
  - blez 06, bgtz 07, and op 01 with rt=0 bltz / rt=1 bgez test signed rs_val.
  - Branch target = IF_ID_PC4 + (ext_imm<<2).
  - j 02: target {PC4[31:28], instr[25:0], 00}.
  - jal 03: same target, plus RegWrite=1, ID_rd=31, ID_R=1, JALControl=1.
  - jr funct 08: target rs_val.
  - jalr funct 09: target rs_val, plus link to rd.
  - There is no delay slot. ID_PCSrc=1 when the branch is taken or on any jump; otherwise 0 and ID_new_PC is don't-care.
- Unknown opcode or funct: every control output is 0 (NOP).
- Hazard detection (ID_stall=1)
  - Raised when a used source register is nonzero and equals a pending destination with its RegWrite set, in EX, EX_MEM or MEM_SAD.
  - rs is not used by j, jal, lui or immediate shifts.
  - rt is used by R-type, stores, beq and bne.
  - A WB match does not stall; the read bypass covers it.
- While ID_stall=1, ID_PCSrc=0.

Test Plan:
1. Reset; then write $2=5 via the WB ports; decode add $3,$2,$2 -> rs_val=rt_val=5, ALUControl=0, ID_R=1, RegWrite=1, ID_rd=3.
2. Bypass: decode or $4,$2,$0 while WB writes $2=9 in the same cycle -> rs_val=9.
3. Hazard: decode addi $5,$2,1 with EX_WriteRegister=2 and ID_EX_RegWrite=1 -> ID_stall=1. Repeat with the match only in MEM_SAD -> stall=1. With $0 as the destination -> stall=0.
4. Branch: decode beq $2,$2,-1 with $2=5 and PC4=0x40 -> ID_PCSrc=1, ID_new_PC=0x3C. Same with bne -> ID_PCSrc=0.
5. jal 0x100 with PC4=0x10 -> ID_new_PC=0x400, ID_rd=31, JALControl=1. jr $31 with $31=0x20 -> ID_new_PC=0x20.
6. Decode andi with imm=0xFFFF -> ext_imm=0x0000FFFF; lh -> MemRead=1, Half=1. Op 38 -> frame_shift=1, MemRead=1. Unknown op 3F -> all controls 0.

Source files
------------

// File: rtl/instruction_decode_unit.sv
// ID stage of the six-stage MIPS32 pipeline: register file with write-back
// bypass, instruction decode, branch/jump resolution and RAW stall detection.
module instruction_decode_unit (
   input  logic        Clk,
   input  logic        Reset,
   input  logic [31:0] IF_ID_Instruction,
   input  logic [31:0] IF_ID_PC4,
   input  logic [31:0] WB_WriteData,
   input  logic [4:0]  MEM_WB_WriteRegister,
   input  logic        MEM_WB_RegWrite,
   input  logic        ID_EX_RegWrite,
   input  logic        EX_MEM_RegWrite,
   input  logic        MEM_SAD_RegWrite,
   input  logic [4:0]  EX_WriteRegister,
   input  logic [4:0]  EX_MEM_WriteRegister,
   input  logic [4:0]  MEM_SAD_WriteRegister,
   output logic [31:0] ID_rs_val,
   output logic [31:0] ID_rt_val,
   output logic [31:0] ID_ext_imm,
   output logic [4:0]  ID_rt,
   output logic [4:0]  ID_rd,
   output logic [4:0]  ID_shamt,
   output logic [3:0]  ID_ALUControl,
   output logic        ID_R,
   output logic        ID_RegWrite,
   output logic        ID_MemWrite,
   output logic        ID_MemRead,
   output logic        ID_HalfControl,
   output logic        ID_ByteControl,
   output logic        ID_JALControl,
   output logic        ID_frame_shift,
   output logic        ID_window_shift,
   output logic        ID_PCSrc,
   output logic [31:0] ID_new_PC,
   output logic        ID_stall
);

   typedef enum logic [3:0] {
      ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3,
      ALU_XOR = 4'd4, ALU_NOR = 4'd5, ALU_SLT = 4'd6, ALU_SLTU = 4'd7,
      ALU_SLL = 4'd8, ALU_SRL = 4'd9, ALU_SRA = 4'd10, ALU_SLLV = 4'd11,
      ALU_SRLV = 4'd12, ALU_SRAV = 4'd13, ALU_LUI = 4'd14, ALU_MUL = 4'd15
   } aluOp_e;

   logic [31:0] regs_q [32];
   logic [5:0]  opcode, funct;
   logic [4:0]  rsIdx, rtIdx, rdIdx;
   logic [15:0] imm;
   logic        wbHitRs, wbHitRt;

   aluOp_e      aluOp;
   logic        zeroExt, usesRs, usesRt, isJump, jumpReg, branchTaken, linkRd31;
   logic        rsPending, rtPending;
   logic [31:0] branchTarget, jumpTarget;

   assign opcode = IF_ID_Instruction[31:26];
   assign rsIdx  = IF_ID_Instruction[25:21];
   assign rtIdx  = IF_ID_Instruction[20:16];
   assign rdIdx  = IF_ID_Instruction[15:11];
   assign funct  = IF_ID_Instruction[5:0];
   assign imm    = IF_ID_Instruction[15:0];

   assign ID_rt    = rtIdx;
   assign ID_shamt = IF_ID_Instruction[10:6];

   // Register file: cleared asynchronously, written from WB except $0
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < 32; i++) regs_q[i] <= '0;
      end else if (MEM_WB_RegWrite && (MEM_WB_WriteRegister != 5'd0)) begin
         regs_q[MEM_WB_WriteRegister] <= WB_WriteData;
      end
   end

   // Reads see $0 as zero and take same-cycle WB data ahead of the array
   assign wbHitRs = MEM_WB_RegWrite && (MEM_WB_WriteRegister == rsIdx) && (rsIdx != 5'd0);
   assign wbHitRt = MEM_WB_RegWrite && (MEM_WB_WriteRegister == rtIdx) && (rtIdx != 5'd0);
   assign ID_rs_val = (rsIdx == 5'd0) ? 32'd0 : (wbHitRs ? WB_WriteData : regs_q[rsIdx]);
   assign ID_rt_val = (rtIdx == 5'd0) ? 32'd0 : (wbHitRt ? WB_WriteData : regs_q[rtIdx]);

   // Main decoder: control flags, operand usage and branch/jump resolution
   always_comb begin
      aluOp           = ALU_ADD;
      ID_R            = 1'b0;
      ID_RegWrite     = 1'b0;
      ID_MemWrite     = 1'b0;
      ID_MemRead      = 1'b0;
      ID_HalfControl  = 1'b0;
      ID_ByteControl  = 1'b0;
      ID_JALControl   = 1'b0;
      ID_frame_shift  = 1'b0;
      ID_window_shift = 1'b0;
      zeroExt         = 1'b0;
      usesRs          = 1'b0;
      usesRt          = 1'b0;
      isJump          = 1'b0;
      jumpReg         = 1'b0;
      branchTaken     = 1'b0;
      linkRd31        = 1'b0;
      case (opcode)
         6'h00: begin
            ID_R        = 1'b1;
            ID_RegWrite = 1'b1;
            usesRs      = 1'b1;
            usesRt      = 1'b1;
            case (funct)
               6'h20, 6'h21: aluOp = ALU_ADD;
               6'h22, 6'h23: aluOp = ALU_SUB;
               6'h24: aluOp = ALU_AND;
               6'h25: aluOp = ALU_OR;
               6'h26: aluOp = ALU_XOR;
               6'h27: aluOp = ALU_NOR;
               6'h2A: aluOp = ALU_SLT;
               6'h2B: aluOp = ALU_SLTU;
               6'h00: begin aluOp = ALU_SLL; usesRs = 1'b0; end
               6'h02: begin aluOp = ALU_SRL; usesRs = 1'b0; end
               6'h03: begin aluOp = ALU_SRA; usesRs = 1'b0; end
               6'h04: aluOp = ALU_SLLV;
               6'h06: aluOp = ALU_SRLV;
               6'h07: aluOp = ALU_SRAV;
               6'h08: begin
                  ID_RegWrite = 1'b0;
                  usesRt      = 1'b0;
                  isJump      = 1'b1;
                  jumpReg     = 1'b1;
               end
               6'h09: begin
                  ID_JALControl = 1'b1;
                  usesRt        = 1'b0;
                  isJump        = 1'b1;
                  jumpReg       = 1'b1;
               end
               default: begin
                  ID_R        = 1'b0;
                  ID_RegWrite = 1'b0;
                  usesRs      = 1'b0;
                  usesRt      = 1'b0;
               end
            endcase
         end
         6'h1C: begin
            if (funct == 6'h02) begin
               aluOp       = ALU_MUL;
               ID_R        = 1'b1;
               ID_RegWrite = 1'b1;
               usesRs      = 1'b1;
               usesRt      = 1'b1;
            end
         end
         6'h08, 6'h09: begin ID_RegWrite = 1'b1; usesRs = 1'b1; aluOp = ALU_ADD; end
         6'h0A: begin ID_RegWrite = 1'b1; usesRs = 1'b1; aluOp = ALU_SLT; end
         6'h0B: begin ID_RegWrite = 1'b1; usesRs = 1'b1; aluOp = ALU_SLTU; end
         6'h0C: begin ID_RegWrite = 1'b1; usesRs = 1'b1; aluOp = ALU_AND; zeroExt = 1'b1; end
         6'h0D: begin ID_RegWrite = 1'b1; usesRs = 1'b1; aluOp = ALU_OR;  zeroExt = 1'b1; end
         6'h0E: begin ID_RegWrite = 1'b1; usesRs = 1'b1; aluOp = ALU_XOR; zeroExt = 1'b1; end
         6'h0F: begin ID_RegWrite = 1'b1; aluOp = ALU_LUI; end
         6'h23, 6'h21, 6'h20, 6'h38, 6'h39: begin
            ID_RegWrite     = 1'b1;
            ID_MemRead      = 1'b1;
            usesRs          = 1'b1;
            ID_HalfControl  = (opcode == 6'h21);
            ID_ByteControl  = (opcode == 6'h20);
            ID_frame_shift  = (opcode == 6'h38);
            ID_window_shift = (opcode == 6'h39);
         end
         6'h2B, 6'h29, 6'h28: begin
            ID_MemWrite    = 1'b1;
            usesRs         = 1'b1;
            usesRt         = 1'b1;
            ID_HalfControl = (opcode == 6'h29);
            ID_ByteControl = (opcode == 6'h28);
         end
         6'h04: begin usesRs = 1'b1; usesRt = 1'b1; branchTaken = (ID_rs_val == ID_rt_val); end
         6'h05: begin usesRs = 1'b1; usesRt = 1'b1; branchTaken = (ID_rs_val != ID_rt_val); end
         6'h06: begin usesRs = 1'b1; branchTaken = ID_rs_val[31] || (ID_rs_val == 32'd0); end
         6'h07: begin usesRs = 1'b1; branchTaken = !ID_rs_val[31] && (ID_rs_val != 32'd0); end
         6'h01: begin
            if (rtIdx == 5'd0) begin
               usesRs      = 1'b1;
               branchTaken = ID_rs_val[31];
            end else if (rtIdx == 5'd1) begin
               usesRs      = 1'b1;
               branchTaken = !ID_rs_val[31];
            end
         end
         6'h02: isJump = 1'b1;
         6'h03: begin
            isJump        = 1'b1;
            ID_R          = 1'b1;
            ID_RegWrite   = 1'b1;
            ID_JALControl = 1'b1;
            linkRd31      = 1'b1;
         end
         default: ;
      endcase
   end

   assign ID_ALUControl = aluOp;
   assign ID_ext_imm    = zeroExt ? {16'd0, imm} : {{16{imm[15]}}, imm};
   assign ID_rd         = linkRd31 ? 5'd31 : rdIdx;

   // A used, nonzero source that a later stage will still write forces a stall
   assign rsPending = usesRs && (rsIdx != 5'd0) &&
                      ((ID_EX_RegWrite   && (EX_WriteRegister      == rsIdx)) ||
                       (EX_MEM_RegWrite  && (EX_MEM_WriteRegister  == rsIdx)) ||
                       (MEM_SAD_RegWrite && (MEM_SAD_WriteRegister == rsIdx)));
   assign rtPending = usesRt && (rtIdx != 5'd0) &&
                      ((ID_EX_RegWrite   && (EX_WriteRegister      == rtIdx)) ||
                       (EX_MEM_RegWrite  && (EX_MEM_WriteRegister  == rtIdx)) ||
                       (MEM_SAD_RegWrite && (MEM_SAD_WriteRegister == rtIdx)));
   assign ID_stall = rsPending || rtPending;

   assign branchTarget = IF_ID_PC4 + {ID_ext_imm[29:0], 2'b00};
   assign jumpTarget   = {IF_ID_PC4[31:28], IF_ID_Instruction[25:0], 2'b00};
   assign ID_new_PC    = jumpReg ? ID_rs_val : (isJump ? jumpTarget : branchTarget);
   assign ID_PCSrc     = (isJump || branchTaken) && !ID_stall;

endmodule

// File: tb/tb_instruction_decode_unit.sv
// Directed, table-driven bench for the ID stage decoder and register file.
module tb_instruction_decode_unit;

   logic        Clk = 1'b0;
   logic        Reset = 1'b0;
   logic [31:0] IF_ID_Instruction = '0;
   logic [31:0] IF_ID_PC4 = '0;
   logic [31:0] WB_WriteData = '0;
   logic [4:0]  MEM_WB_WriteRegister = '0;
   logic        MEM_WB_RegWrite = 1'b0;
   logic        ID_EX_RegWrite = 1'b0, EX_MEM_RegWrite = 1'b0, MEM_SAD_RegWrite = 1'b0;
   logic [4:0]  EX_WriteRegister = '0, EX_MEM_WriteRegister = '0, MEM_SAD_WriteRegister = '0;
   logic [31:0] ID_rs_val, ID_rt_val, ID_ext_imm, ID_new_PC;
   logic [4:0]  ID_rt, ID_rd, ID_shamt;
   logic [3:0]  ID_ALUControl;
   logic        ID_R, ID_RegWrite, ID_MemWrite, ID_MemRead, ID_HalfControl, ID_ByteControl;
   logic        ID_JALControl, ID_frame_shift, ID_window_shift, ID_PCSrc, ID_stall;

   int passCount = 0;
   int checkCount = 0;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc4;
      int          stage;
      logic [4:0]  pendReg;
      logic [31:0] rsVal;
      logic [31:0] rtVal;
      logic [31:0] extImm;
      logic [4:0]  rd;
      logic [3:0]  alu;
      logic [10:0] ctrl;
      logic [31:0] newPc;
   } vec_t;

   vec_t vecs[$];

   instruction_decode_unit dut (
      .Clk(Clk), .Reset(Reset),
      .IF_ID_Instruction(IF_ID_Instruction), .IF_ID_PC4(IF_ID_PC4),
      .WB_WriteData(WB_WriteData), .MEM_WB_WriteRegister(MEM_WB_WriteRegister),
      .MEM_WB_RegWrite(MEM_WB_RegWrite),
      .ID_EX_RegWrite(ID_EX_RegWrite), .EX_MEM_RegWrite(EX_MEM_RegWrite),
      .MEM_SAD_RegWrite(MEM_SAD_RegWrite),
      .EX_WriteRegister(EX_WriteRegister), .EX_MEM_WriteRegister(EX_MEM_WriteRegister),
      .MEM_SAD_WriteRegister(MEM_SAD_WriteRegister),
      .ID_rs_val(ID_rs_val), .ID_rt_val(ID_rt_val), .ID_ext_imm(ID_ext_imm),
      .ID_rt(ID_rt), .ID_rd(ID_rd), .ID_shamt(ID_shamt), .ID_ALUControl(ID_ALUControl),
      .ID_R(ID_R), .ID_RegWrite(ID_RegWrite), .ID_MemWrite(ID_MemWrite),
      .ID_MemRead(ID_MemRead), .ID_HalfControl(ID_HalfControl),
      .ID_ByteControl(ID_ByteControl), .ID_JALControl(ID_JALControl),
      .ID_frame_shift(ID_frame_shift), .ID_window_shift(ID_window_shift),
      .ID_PCSrc(ID_PCSrc), .ID_new_PC(ID_new_PC), .ID_stall(ID_stall)
   );

   // Free-running clock
   always #5 Clk = ~Clk;

   function automatic logic [31:0] rType(input logic [4:0] rs, rt, rd, sh, input logic [5:0] fn);
      return {6'h00, rs, rt, rd, sh, fn};
   endfunction

   function automatic logic [31:0] iType(input logic [5:0] op, input logic [4:0] rs, rt,
                                         input logic [15:0] im);
      return {op, rs, rt, im};
   endfunction

   function automatic logic [31:0] jType(input logic [5:0] op, input logic [25:0] tgt);
      return {op, tgt};
   endfunction

   task automatic addVec(input logic [31:0] instr, pc4, input int stage, input logic [4:0] pendReg,
                         input logic [31:0] rsVal, rtVal, extImm, input logic [4:0] rd,
                         input logic [3:0] alu, input logic [10:0] ctrl, input logic [31:0] newPc);
      vec_t v;
      v.instr = instr; v.pc4 = pc4; v.stage = stage; v.pendReg = pendReg;
      v.rsVal = rsVal; v.rtVal = rtVal; v.extImm = extImm; v.rd = rd;
      v.alu = alu; v.ctrl = ctrl; v.newPc = newPc;
      vecs.push_back(v);
   endtask

   task automatic check32(input string name, input logic [31:0] actual, expected);
      checkCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
   endtask

   task automatic writeReg(input logic [4:0] idx, input logic [31:0] data);
      @(negedge Clk);
      MEM_WB_RegWrite = 1'b1;
      MEM_WB_WriteRegister = idx;
      WB_WriteData = data;
      @(negedge Clk);
      MEM_WB_RegWrite = 1'b0;
   endtask

   task automatic applyStimulus(input vec_t v);
      @(negedge Clk);
      IF_ID_Instruction = v.instr;
      IF_ID_PC4 = v.pc4;
      EX_WriteRegister = v.pendReg;
      EX_MEM_WriteRegister = v.pendReg;
      MEM_SAD_WriteRegister = v.pendReg;
      ID_EX_RegWrite = (v.stage == 1);
      EX_MEM_RegWrite = (v.stage == 2);
      MEM_SAD_RegWrite = (v.stage == 3);
      #1;
   endtask

   task automatic checkOutput(input int idx, input vec_t v);
      logic [10:0] ctrl;
      string tag;
      ctrl = {ID_R, ID_RegWrite, ID_MemWrite, ID_MemRead, ID_HalfControl, ID_ByteControl,
              ID_JALControl, ID_frame_shift, ID_window_shift, ID_PCSrc, ID_stall};
      tag = $sformatf("v%0d", idx);
      check32({tag, ".rs_val"}, ID_rs_val, v.rsVal);
      check32({tag, ".rt_val"}, ID_rt_val, v.rtVal);
      check32({tag, ".ext_imm"}, ID_ext_imm, v.extImm);
      check32({tag, ".rd"}, {27'd0, ID_rd}, {27'd0, v.rd});
      check32({tag, ".alu"}, {28'd0, ID_ALUControl}, {28'd0, v.alu});
      check32({tag, ".ctrl"}, {21'd0, ctrl}, {21'd0, v.ctrl});
      if (v.ctrl[1]) check32({tag, ".new_pc"}, ID_new_PC, v.newPc);
   endtask

   // Vector table, then hand-written sequences for bypass, $0 and async reset
   initial begin
      // ctrl = {R, RegWrite, MemWrite, MemRead, Half, Byte, JAL, frame, window, PCSrc, stall}
      addVec(rType(2,2,3,0,6'h20), 0, 0, 0, 5, 5, 32'h1820, 3, 0, 11'b11000000000, 0);
      addVec(rType(6,2,7,0,6'h22), 0, 0, 0, 32'hFFFFFFFD, 5, 32'h3822, 7, 1, 11'b11000000000, 0);
      addVec(rType(2,0,9,3,6'h00), 0, 1, 2, 5, 0, 32'h48C0, 9, 8, 11'b11000000000, 0);
      addVec(rType(0,6,8,4,6'h03), 0, 0, 0, 0, 32'hFFFFFFFD, 32'h4103, 8, 10, 11'b11000000000, 0);
      addVec(iType(6'h1C,2,6,16'h5002), 0, 0, 0, 5, 32'hFFFFFFFD, 32'h5002, 10, 15, 11'b11000000000, 0);
      addVec(iType(6'h0C,2,5,16'hFFFF), 0, 0, 0, 5, 0, 32'h0000FFFF, 31, 2, 11'b01000000000, 0);
      addVec(iType(6'h08,2,5,16'hFFFF), 0, 0, 0, 5, 0, 32'hFFFFFFFF, 31, 0, 11'b01000000000, 0);
      addVec(iType(6'h08,2,5,16'h0001), 0, 1, 2, 5, 0, 1, 0, 0, 11'b01000000001, 0);
      addVec(iType(6'h08,2,5,16'h0001), 0, 3, 2, 5, 0, 1, 0, 0, 11'b01000000001, 0);
      addVec(iType(6'h08,0,5,16'h0001), 0, 1, 0, 0, 0, 1, 0, 0, 11'b01000000000, 0);
      addVec(iType(6'h08,2,5,16'h0001), 0, 0, 2, 5, 0, 1, 0, 0, 11'b01000000000, 0);
      addVec(iType(6'h0F,2,5,16'h1234), 0, 1, 2, 5, 0, 32'h1234, 2, 14, 11'b01000000000, 0);
      addVec(iType(6'h21,2,5,16'h0004), 0, 0, 0, 5, 0, 4, 0, 0, 11'b01011000000, 0);
      addVec(iType(6'h28,6,2,16'h0008), 0, 2, 2, 32'hFFFFFFFD, 5, 8, 0, 0, 11'b00100100001, 0);
      addVec(iType(6'h38,2,5,16'h0000), 0, 0, 0, 5, 0, 0, 0, 0, 11'b01010001000, 0);
      addVec(iType(6'h39,2,5,16'h0000), 0, 0, 0, 5, 0, 0, 0, 0, 11'b01010000100, 0);
      addVec(iType(6'h3F,2,5,16'h0010), 0, 0, 0, 5, 0, 32'h10, 0, 0, 11'b00000000000, 0);
      addVec(iType(6'h04,2,2,16'hFFFF), 32'h40, 0, 0, 5, 5, 32'hFFFFFFFF, 31, 0, 11'b00000000010, 32'h3C);
      addVec(iType(6'h05,2,2,16'hFFFF), 32'h40, 0, 0, 5, 5, 32'hFFFFFFFF, 31, 0, 11'b00000000000, 0);
      addVec(iType(6'h04,2,2,16'hFFFF), 32'h40, 1, 2, 5, 5, 32'hFFFFFFFF, 31, 0, 11'b00000000001, 0);
      addVec(iType(6'h05,2,6,16'h0002), 32'h100, 0, 0, 5, 32'hFFFFFFFD, 2, 0, 0, 11'b00000000010, 32'h108);
      addVec(iType(6'h01,6,0,16'h0004), 32'h200, 0, 0, 32'hFFFFFFFD, 0, 4, 0, 0, 11'b00000000010, 32'h210);
      addVec(iType(6'h01,6,1,16'h0004), 32'h200, 0, 0, 32'hFFFFFFFD, 0, 4, 0, 0, 11'b00000000000, 0);
      addVec(iType(6'h07,2,0,16'hFFFE), 32'h80, 0, 0, 5, 0, 32'hFFFFFFFE, 31, 0, 11'b00000000010, 32'h78);
      addVec(iType(6'h06,2,0,16'hFFFE), 32'h80, 0, 0, 5, 0, 32'hFFFFFFFE, 31, 0, 11'b00000000000, 0);
      addVec(jType(6'h02,26'h40), 32'hA0000010, 0, 0, 0, 0, 32'h40, 0, 0, 11'b00000000010, 32'hA0000100);
      addVec(jType(6'h03,26'h100), 32'h10, 0, 0, 0, 0, 32'h100, 31, 0, 11'b11000010010, 32'h400);
      addVec(rType(31,0,0,0,6'h08), 0, 0, 0, 32'h20, 0, 8, 0, 0, 11'b10000000010, 32'h20);
      addVec(rType(31,0,4,0,6'h09), 0, 0, 0, 32'h20, 0, 32'h2009, 4, 0, 11'b11000010010, 32'h20);
      addVec(rType(2,6,3,0,6'h3F), 0, 0, 0, 5, 32'hFFFFFFFD, 32'h183F, 3, 0, 11'b00000000000, 0);
      addVec(rType(2,6,4,0,6'h25), 0, 2, 6, 5, 32'hFFFFFFFD, 32'h2025, 4, 3, 11'b11000000001, 0);
      addVec(rType(31,0,0,0,6'h08), 0, 1, 31, 32'h20, 0, 8, 0, 0, 11'b10000000001, 0);

      #2 Reset = 1'b1;
      #10 Reset = 1'b0;
      @(negedge Clk);
      IF_ID_Instruction = rType(2, 31, 3, 0, 6'h20);
      #1;
      check32("reset.rs_val", ID_rs_val, 0);
      check32("reset.rt_val", ID_rt_val, 0);

      writeReg(2, 5);
      writeReg(6, 32'hFFFFFFFD);
      writeReg(31, 32'h20);

      foreach (vecs[i]) begin
         applyStimulus(vecs[i]);
         checkOutput(i, vecs[i]);
      end

      @(negedge Clk);
      ID_EX_RegWrite = 1'b0; EX_MEM_RegWrite = 1'b0; MEM_SAD_RegWrite = 1'b0;
      IF_ID_Instruction = rType(0, 6, 8, 4, 6'h03);
      #1;
      check32("fields.rt", {27'd0, ID_rt}, 6);
      check32("fields.shamt", {27'd0, ID_shamt}, 4);

      @(negedge Clk);
      IF_ID_Instruction = rType(2, 0, 4, 0, 6'h25);
      MEM_WB_RegWrite = 1'b1; MEM_WB_WriteRegister = 2; WB_WriteData = 9;
      #1;
      check32("bypass.rs_val", ID_rs_val, 9);
      check32("bypass.rt_zero", ID_rt_val, 0);
      @(negedge Clk);
      MEM_WB_RegWrite = 1'b0;
      #1;
      check32("written.rs_val", ID_rs_val, 9);

      @(negedge Clk);
      IF_ID_Instruction = rType(0, 0, 4, 0, 6'h25);
      MEM_WB_RegWrite = 1'b1; MEM_WB_WriteRegister = 0; WB_WriteData = 32'h77;
      #1;
      check32("zero.bypass", ID_rs_val, 0);
      @(negedge Clk);
      MEM_WB_RegWrite = 1'b0;
      #1;
      check32("zero.written", ID_rt_val, 0);

      @(negedge Clk);
      IF_ID_Instruction = rType(2, 31, 3, 0, 6'h20);
      #1;
      check32("prereset.rs_val", ID_rs_val, 9);
      Reset = 1'b1;
      #1;
      check32("asyncreset.rs_val", ID_rs_val, 0);
      check32("asyncreset.rt_val", ID_rt_val, 0);
      @(negedge Clk);
      Reset = 1'b0;

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
